// File: rtl/spi_master_arbiter_pkg.sv
// ============================================================================
// Module   : spi_master_arbiter_pkg
// Brief    : Shared types and widths for the SPI master arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_master_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CFG  = 3'd1,
        XMIT = 3'd2,
        WAIT = 3'd3,
        RESP = 3'd4
    } state_t;

    localparam int PKT_SIZE_W = 6;
    localparam int CS_ADDR_W  = 32;

endpackage

`default_nettype wire

// File: rtl/spi_rr_arbiter.sv
// ============================================================================
// Module   : spi_rr_arbiter
// Brief    : One-hot arbiter whose search starts at a rotating pointer;
//            with RR_EN=0 the pointer is a constant 0 (fixed priority).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_rr_arbiter #(
    parameter int NREQ  = 4,
    parameter bit RR_EN = 1'b0,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NREQ-1:0]  req,
    input  logic             update,
    input  logic [IDX_W-1:0] upd_idx,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] ptr
);

    localparam int SW = IDX_W + 1;

    logic [IDX_W:0] w_pos;
    logic           w_found;

    // Walk the requesters in circular order starting at the pointer.
    always_comb begin
        grant   = '0;
        w_found = 1'b0;
        w_pos   = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_pos = {1'b0, ptr} + SW'(k);
            if (w_pos >= SW'(NREQ)) begin
                w_pos = w_pos - SW'(NREQ);
            end
            if (!w_found && req[w_pos[IDX_W-1:0]]) begin
                grant[w_pos[IDX_W-1:0]] = 1'b1;
                w_found                 = 1'b1;
            end
        end
    end

    generate
        if (RR_EN) begin : g_rr_ptr
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    ptr <= '0;
                end else if (update) begin
                    ptr <= (upd_idx == IDX_W'(NREQ - 1)) ? '0 : upd_idx + IDX_W'(1);
                end
            end
        end else begin : g_fixed_ptr
            logic unused_upd;
            assign unused_upd = ^{clk, reset, update, upd_idx};
            assign ptr        = '0;
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/spi_master_arbiter.sv
// ============================================================================
// Module   : spi_master_arbiter
// Brief    : Shares one spi_master among NREQ requesters; sequences the
//            size/chip-select writes, the data push and the response.
//            Define SPI_MASTER_ARBITER_RR_EN for round-robin arbitration.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_master_arbiter
    import spi_master_arbiter_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int NBITS = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NREQ-1:0]            req_val,
    output logic [NREQ-1:0]            req_rdy,
    input  logic [NREQ*NBITS-1:0]      req_msg,
    input  logic [NREQ*PKT_SIZE_W-1:0] req_pkt_size,
    output logic [NREQ-1:0]            resp_val,
    input  logic [NREQ-1:0]            resp_rdy,
    output logic [NBITS-1:0]           resp_msg,
    output logic                       spi_pkt_size_val,
    input  logic                       spi_pkt_size_rdy,
    output logic [31:0]                spi_pkt_size_msg,
    output logic                       spi_cs_addr_val,
    input  logic                       spi_cs_addr_rdy,
    output logic [CS_ADDR_W-1:0]       spi_cs_addr_msg,
    output logic                       spi_recv_val,
    input  logic                       spi_recv_rdy,
    output logic [NBITS-1:0]           spi_recv_msg,
    input  logic                       spi_send_val,
    output logic                       spi_send_rdy,
    input  logic [NBITS-1:0]           spi_send_msg
);

    localparam int IDX_W = $clog2(NREQ);
`ifdef SPI_MASTER_ARBITER_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    state_t                r_state;
    state_t                w_state_nxt;
    logic [IDX_W-1:0]      r_idx;
    logic [NREQ-1:0]       r_grant;
    logic [NBITS-1:0]      r_data;
    logic [PKT_SIZE_W-1:0] r_size;
    logic [NBITS-1:0]      r_resp;
    logic                  r_size_done;
    logic                  r_cs_done;

    logic [NREQ-1:0]       w_grant;
    logic [IDX_W-1:0]      w_ptr_unused;
    logic [IDX_W-1:0]      w_grant_idx;
    logic [NBITS-1:0]      w_grant_word;
    logic [PKT_SIZE_W-1:0] w_grant_size;
    logic                  w_accept;
    logic                  w_size_fire;
    logic                  w_cs_fire;
    logic                  w_send_fire;
    logic                  w_resp_fire;

    spi_rr_arbiter #(
        .NREQ  (NREQ),
        .RR_EN (RR_EN),
        .IDX_W (IDX_W)
    ) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (req_val),
        .update  (w_resp_fire),
        .upd_idx (r_idx),
        .grant   (w_grant),
        .ptr     (w_ptr_unused)
    );

    always_comb begin
        w_grant_idx  = '0;
        w_grant_word = '0;
        w_grant_size = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_grant_idx  = IDX_W'(i);
                w_grant_word = req_msg[i*NBITS +: NBITS];
                w_grant_size = req_pkt_size[i*PKT_SIZE_W +: PKT_SIZE_W];
            end
        end
    end

    // Fire strobes come from state and inputs only, never from the outputs.
    assign w_accept    = (r_state == IDLE) && (|(w_grant & req_val));
    assign w_size_fire = (r_state == CFG) && !r_size_done && spi_pkt_size_rdy;
    assign w_cs_fire   = (r_state == CFG) && !r_cs_done && spi_cs_addr_rdy;
    assign w_send_fire = (r_state == WAIT) && spi_send_val;
    assign w_resp_fire = (r_state == RESP) && (|(r_grant & resp_rdy));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        req_rdy          = '0;
        resp_val         = '0;
        spi_pkt_size_val = 1'b0;
        spi_cs_addr_val  = 1'b0;
        spi_recv_val     = 1'b0;
        spi_send_rdy     = 1'b0;
        case (r_state)
            IDLE: begin
                req_rdy = w_grant;
                if (w_accept) w_state_nxt = CFG;
            end
            CFG: begin
                spi_pkt_size_val = !r_size_done;
                spi_cs_addr_val  = !r_cs_done;
                if ((r_size_done || w_size_fire) && (r_cs_done || w_cs_fire)) begin
                    w_state_nxt = XMIT;
                end
            end
            XMIT: begin
                spi_recv_val = 1'b1;
                if (spi_recv_rdy) w_state_nxt = WAIT;
            end
            WAIT: begin
                spi_send_rdy = 1'b1;
                if (w_send_fire) w_state_nxt = RESP;
            end
            RESP: begin
                resp_val = r_grant;
                if (w_resp_fire) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx       <= '0;
            r_grant     <= '0;
            r_data      <= '0;
            r_size      <= '0;
            r_resp      <= '0;
            r_size_done <= 1'b0;
            r_cs_done   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_idx       <= w_grant_idx;
                r_grant     <= w_grant;
                r_data      <= w_grant_word;
                r_size      <= (w_grant_size == '0) ? PKT_SIZE_W'(NBITS) : w_grant_size;
                r_size_done <= 1'b0;
                r_cs_done   <= 1'b0;
            end
            if (w_size_fire) r_size_done <= 1'b1;
            if (w_cs_fire)   r_cs_done   <= 1'b1;
            if (w_send_fire) r_resp      <= spi_send_msg;
        end
    end

    assign resp_msg         = r_resp;
    assign spi_recv_msg     = r_data;
    assign spi_pkt_size_msg = 32'(r_size);
    assign spi_cs_addr_msg  = CS_ADDR_W'(r_idx);

endmodule

`default_nettype wire

// File: tb/tb_spi_master_arbiter.sv
// ============================================================================
// Module   : tb_spi_master_arbiter
// Brief    : Directed self-checking bench for spi_master_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_master_arbiter;

    logic         clk;
    logic         reset;
    logic [3:0]   req_val;
    logic [3:0]   req_rdy;
    logic [127:0] req_msg;
    logic [23:0]  req_pkt_size;
    logic [3:0]   resp_val;
    logic [3:0]   resp_rdy;
    logic [31:0]  resp_msg;
    logic         spi_pkt_size_val, spi_pkt_size_rdy;
    logic [31:0]  spi_pkt_size_msg;
    logic         spi_cs_addr_val, spi_cs_addr_rdy;
    logic [31:0]  spi_cs_addr_msg;
    logic         spi_recv_val, spi_recv_rdy;
    logic [31:0]  spi_recv_msg;
    logic         spi_send_val, spi_send_rdy;
    logic [31:0]  spi_send_msg;

    int checks = 0;
    int errors = 0;
    int n_size_wr = 0;
    int n_cs_wr   = 0;

    spi_master_arbiter #(.NREQ(4), .NBITS(32)) dut (
        .clk              (clk),
        .reset            (reset),
        .req_val          (req_val),
        .req_rdy          (req_rdy),
        .req_msg          (req_msg),
        .req_pkt_size     (req_pkt_size),
        .resp_val         (resp_val),
        .resp_rdy         (resp_rdy),
        .resp_msg         (resp_msg),
        .spi_pkt_size_val (spi_pkt_size_val),
        .spi_pkt_size_rdy (spi_pkt_size_rdy),
        .spi_pkt_size_msg (spi_pkt_size_msg),
        .spi_cs_addr_val  (spi_cs_addr_val),
        .spi_cs_addr_rdy  (spi_cs_addr_rdy),
        .spi_cs_addr_msg  (spi_cs_addr_msg),
        .spi_recv_val     (spi_recv_val),
        .spi_recv_rdy     (spi_recv_rdy),
        .spi_recv_msg     (spi_recv_msg),
        .spi_send_val     (spi_send_val),
        .spi_send_rdy     (spi_send_rdy),
        .spi_send_msg     (spi_send_msg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (!reset && spi_pkt_size_val && spi_pkt_size_rdy) n_size_wr++;
        if (!reset && spi_cs_addr_val && spi_cs_addr_rdy)   n_cs_wr++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Runs one transaction from IDLE with every master handshake ready.
    task automatic do_txn(input int idx, input logic [31:0] ret, input logic [31:0] exp_size,
                          input logic [31:0] exp_word, input logic [3:0] hold_val,
                          input bit scramble);
        #1;
        check("grant", {28'd0, req_rdy}, 32'(4'b0001 << idx));
        step();
        req_val = hold_val;
        if (scramble) req_msg = ~req_msg;
        check("cs_addr_msg", spi_cs_addr_msg, 32'(idx));
        check("pkt_size_msg", spi_pkt_size_msg, exp_size);
        step();
        check("recv_msg", spi_recv_msg, exp_word);
        step();
        check("send_rdy", {31'd0, spi_send_rdy}, 32'd1);
        spi_send_val = 1'b1;
        spi_send_msg = ret;
        step();
        spi_send_val = 1'b0;
        check("resp_val", {28'd0, resp_val}, 32'(4'b0001 << idx));
        check("resp_msg", resp_msg, ret);
        resp_rdy = 4'b0001 << idx;
        step();
        resp_rdy = 4'b0000;
        check("resp_val_drop", {28'd0, resp_val}, 32'd0);
    endtask

    initial begin
        reset            = 1'b1;
        req_val          = '0;
        req_msg          = '0;
        req_pkt_size     = '0;
        resp_rdy         = '0;
        spi_pkt_size_rdy = 1'b1;
        spi_cs_addr_rdy  = 1'b1;
        spi_recv_rdy     = 1'b1;
        spi_send_val     = 1'b0;
        spi_send_msg     = '0;
        #1;
        check("rst_req_rdy", {28'd0, req_rdy}, 32'd0);
        check("rst_vals", {27'd0, spi_pkt_size_val, spi_cs_addr_val, spi_recv_val,
                           spi_send_rdy, |resp_val}, 32'd0);
        check("rst_msgs", resp_msg | spi_recv_msg | spi_pkt_size_msg | spi_cs_addr_msg, 32'd0);
        step();
        step();
        reset = 1'b0;
        step();

        // Contention: all four requesting continuously.
        for (int i = 0; i < 4; i++) begin
            req_msg[i*32 +: 32]     = 32'hC0DE_0000 | 32'(i);
            req_pkt_size[i*6 +: 6]  = 6'd8;
        end
        req_val = 4'b1111;
`ifdef SPI_MASTER_ARBITER_RR_EN
        do_txn(0, 32'h5000, 32'd8, 32'hC0DE_0000, 4'b1111, 1'b0);
        do_txn(1, 32'h5001, 32'd8, 32'hC0DE_0001, 4'b1111, 1'b0);
        do_txn(2, 32'h5002, 32'd8, 32'hC0DE_0002, 4'b1111, 1'b0);
        do_txn(3, 32'h5003, 32'd8, 32'hC0DE_0003, 4'b1111, 1'b0);
        do_txn(0, 32'h5004, 32'd8, 32'hC0DE_0000, 4'b1111, 1'b0);
`else
        do_txn(0, 32'h5000, 32'd8, 32'hC0DE_0000, 4'b1111, 1'b0);
        do_txn(0, 32'h5001, 32'd8, 32'hC0DE_0000, 4'b1111, 1'b0);
        do_txn(0, 32'h5002, 32'd8, 32'hC0DE_0000, 4'b1111, 1'b0);
`endif
        req_val = 4'b0000;
        step();

        // Single request with the request word changed after acceptance.
        req_msg[2*32 +: 32]    = 32'hA5A5_0F0F;
        req_pkt_size[2*6 +: 6] = 6'd16;
        req_val = 4'b0100;
        do_txn(2, 32'h0000_1234, 32'd16, 32'hA5A5_0F0F, 4'b0000, 1'b1);

        // Size zero maps to the full word width.
        req_msg[0 +: 32]    = 32'h0BAD_F00D;
        req_pkt_size[0 +: 6] = 6'd0;
        req_val = 4'b0001;
        do_txn(0, 32'h7777, 32'd32, 32'h0BAD_F00D, 4'b0000, 1'b0);

        // Split configuration: chip-select write held off for 3 cycles.
        req_msg[1*32 +: 32]    = 32'hDEAD_BEEF;
        req_pkt_size[1*6 +: 6] = 6'd20;
        spi_cs_addr_rdy = 1'b0;
        n_size_wr = 0;
        n_cs_wr   = 0;
        req_val = 4'b0010;
        step();
        req_val = 4'b0000;
        check("split_both_val", {30'd0, spi_pkt_size_val, spi_cs_addr_val}, 32'd3);
        step();
        check("split_size_drop", {30'd0, spi_pkt_size_val, spi_cs_addr_val}, 32'd1);
        check("split_no_xmit", {31'd0, spi_recv_val}, 32'd0);
        step();
        step();
        check("split_still_cfg", {30'd0, spi_cs_addr_val, spi_recv_val}, 32'd2);
        spi_cs_addr_rdy = 1'b1;
        step();
        check("split_xmit", {31'd0, spi_recv_val}, 32'd1);
        check("split_recv_msg", spi_recv_msg, 32'hDEAD_BEEF);
        step();
        spi_send_val = 1'b1;
        spi_send_msg = 32'h0000_2222;
        step();
        spi_send_val = 1'b0;
        resp_rdy = 4'b0010;
        step();
        resp_rdy = 4'b0000;
        check("split_size_writes", 32'(n_size_wr), 32'd1);
        check("split_cs_writes", 32'(n_cs_wr), 32'd1);

        // Response backpressure with other requesters waiting.
        req_val = 4'b0010;
        step();
        req_val = 4'b0000;
        step();
        step();
        spi_send_val = 1'b1;
        spi_send_msg = 32'h0000_B00F;
        step();
        spi_send_val = 1'b0;
        req_val  = 4'b1101;
        resp_rdy = 4'b1101;
        for (int c = 0; c < 5; c++) begin
            check("bp_resp_val", {28'd0, resp_val}, 32'h2);
            check("bp_resp_msg", resp_msg, 32'h0000_B00F);
            check("bp_req_rdy", {28'd0, req_rdy}, 32'd0);
            step();
        end
        resp_rdy = 4'b0010;
        step();
        req_val  = 4'b0000;
        resp_rdy = 4'b0000;
        check("bp_released", {28'd0, resp_val}, 32'd0);
        step();

        // Reset asserted while waiting for the inbound word.
        req_val = 4'b0010;
        step();
        req_val = 4'b0000;
        step();
        step();
        check("pre_rst_send_rdy", {31'd0, spi_send_rdy}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_vals", {27'd0, spi_pkt_size_val, spi_cs_addr_val, spi_recv_val,
                                 spi_send_rdy, |resp_val}, 32'd0);
        check("async_rst_msgs", resp_msg | spi_recv_msg | spi_pkt_size_msg | spi_cs_addr_msg,
              32'd0);
        check("async_rst_req_rdy", {28'd0, req_rdy}, 32'd0);
        step();
        reset = 1'b0;
        step();
        req_val = 4'b1111;
        #1;
        check("post_rst_ptr0", {28'd0, req_rdy}, 32'h1);
        req_msg[3*32 +: 32]    = 32'h3333_CAFE;
        req_pkt_size[3*6 +: 6] = 6'd12;
        req_val = 4'b1000;
        do_txn(3, 32'h0000_9999, 32'd12, 32'h3333_CAFE, 4'b0000, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
